// File: rtl/imem_serial_loader.sv
// Bit-serial program loader: shifts instruction words in MSB first, writes them to instruction memory, then optionally starts the CPU.
// Optional per-word even-parity checking is enabled by defining IMEM_LOADER_PARITY_EN.
module imem_serial_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic                  auto_run,
  input  logic                  sdi,
  input  logic                  sdi_vld,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_dataout,
  output logic                  cpu_enable,
  output logic                  cpu_start,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

`ifdef IMEM_LOADER_PARITY_EN
  localparam int BITS = DATA_WIDTH + 1;
  localparam int SH_W = DATA_WIDTH;
`else
  localparam int BITS = DATA_WIDTH;
  localparam int SH_W = DATA_WIDTH - 1;
`endif
  localparam int CNT_W = $clog2(BITS);

  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, EN, GO, FIN} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, rem_reg;
  logic [SH_W-1:0]         shift_reg;
  logic [DATA_WIDTH-1:0]   data_reg, word;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic                    run_reg;
  logic                    we_reg, we_next;
  logic                    enable_reg, enable_next;
  logic                    start_reg, start_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    err_reg, err_next;
  logic                    accept, bit_in, word_done, last_word, parity_ok;

  assign accept    = (state_reg == IDLE) && load_start;
  // Bits arriving during WRITE already belong to the next word.
  assign bit_in    = sdi_vld && ((state_reg == SHIFT) || (state_reg == WRITE));
  assign word_done = sdi_vld && (state_reg == SHIFT) && (bit_cnt_reg == CNT_W'(BITS - 1));
  assign last_word = (rem_reg == ADDR_WIDTH'(1));

`ifdef IMEM_LOADER_PARITY_EN
  // The final bit is the even-parity bit; the data word is already complete in the shifter.
  assign parity_ok = ~(^shift_reg ^ sdi);
  assign word      = shift_reg;
`else
  assign parity_ok = 1'b1;
  assign word      = {shift_reg, sdi};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (load_start) begin
          if (load_len != '0) state_next = SHIFT;
          else if (auto_run)  state_next = EN;
          else                state_next = FIN;
        end
      end
      SHIFT: if (word_done) state_next = WRITE;
      WRITE: begin
        if (!last_word)               state_next = SHIFT;
        else if (run_reg && !err_reg) state_next = EN;
        else                          state_next = FIN;
      end
      EN:      state_next = GO;
      GO:      state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_next   = (state_next == SHIFT) || (state_next == WRITE) ||
                  (state_next == EN) || (state_next == GO);
    we_next     = word_done && parity_ok;
    start_next  = (state_next == GO);
    done_next   = (state_next == FIN);
    enable_next = enable_reg;
    if (state_next == EN) enable_next = 1'b1;
    else if (accept)      enable_next = 1'b0;
    err_next = err_reg;
    if (accept)                       err_next = 1'b0;
    else if (word_done && !parity_ok) err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg    <= '0;
      rem_reg     <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      bit_cnt_reg <= '0;
      run_reg     <= 1'b0;
      we_reg      <= 1'b0;
      enable_reg  <= 1'b0;
      start_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      we_reg     <= we_next;
      enable_reg <= enable_next;
      start_reg  <= start_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      if (accept) begin
        addr_reg    <= base_addr;
        rem_reg     <= load_len;
        run_reg     <= auto_run;
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
      end else begin
        if (state_reg == WRITE) begin
          addr_reg <= addr_reg + 1'b1;
          rem_reg  <= rem_reg - 1'b1;
        end
        if (word_done) begin
          data_reg    <= word;
          bit_cnt_reg <= '0;
        end else if (bit_in) begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          shift_reg   <= {shift_reg[SH_W-2:0], sdi};
        end
      end
    end
  end

  assign mem_addr    = addr_reg;
  assign mem_we      = we_reg;
  assign mem_dataout = data_reg;
  assign cpu_enable  = enable_reg;
  assign cpu_start   = start_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_imem_serial_loader.sv
// Bench for imem_serial_loader: table of loads plus hand-written reset and parity sequences, writes checked via a scoreboard queue.
// Honours IMEM_LOADER_PARITY_EN by appending a parity bit to every word.
module tb_imem_serial_loader;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] load_len = '0;
  logic          auto_run = 1'b0;
  logic          sdi = 1'b0;
  logic          sdi_vld = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_dataout;
  logic          cpu_enable, cpu_start, busy, done, err;

  imem_serial_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .base_addr(base_addr),
    .load_len(load_len), .auto_run(auto_run), .sdi(sdi), .sdi_vld(sdi_vld),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_dataout(mem_dataout),
    .cpu_enable(cpu_enable), .cpu_start(cpu_start), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Output monitor and scoreboard consumer
  int   we_cnt = 0, start_cnt = 0, done_cnt = 0;
  int   en_cyc = 0, start_cyc = 0, done_cyc = 0, last_we_cyc = 0;
  logic en_prev = 1'b0;
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst_n) begin
      if (mem_we) begin
        we_cnt++;
        last_we_cyc = cyc;
        $display("write addr=0x%02h data=0x%04h", mem_addr, mem_dataout);
        check("we_cpu_enable_low", 32'(cpu_enable), 32'd0);
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL we_unexpected: got write addr=0x%0h data=0x%0h, expected no write", mem_addr, mem_dataout);
        end else begin
          e = exp_q.pop_front();
          check("we_addr", 32'(mem_addr), 32'(e[AW+DW-1:DW]));
          check("we_data", 32'(mem_dataout), 32'(e[DW-1:0]));
        end
      end
      if (cpu_start) begin start_cnt++; start_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cpu_enable && !en_prev) en_cyc = cyc;
    end
    en_prev = cpu_enable;
  end

  int last_bit_cyc = 0;
  int accept_cyc = 0;

  task automatic drive_bit(input logic b, input bit gap);
    int n;
    if (gap) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        sdi_vld = 1'b0;
        sdi = 1'($urandom);
      end
    end
    @(negedge clk);
    sdi = b;
    sdi_vld = 1'b1;
    last_bit_cyc = cyc;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit gap);
    for (int i = DW - 1; i >= 0; i--) drive_bit(w[i], gap);
`ifdef IMEM_LOADER_PARITY_EN
    drive_bit(^w, gap);
`endif
  endtask

  task automatic idle_bus();
    @(negedge clk);
    sdi_vld = 1'b0;
  endtask

  task automatic start_load(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic r);
    @(negedge clk);
    sdi_vld = 1'b0;
    base_addr = b;
    load_len = l;
    auto_run = r;
    load_start = 1'b1;
    accept_cyc = cyc;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic wait_done(input int snap);
    int t;
    t = 0;
    while (done_cnt == snap && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == snap) begin
      total_cnt++;
      $display("FAIL done_timeout: got no done pulse, expected one within 600 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic          run;
    bit            gap;
    bit            mid;
    logic [DW-1:0] mask;
    int            exp_start;
    logic          exp_en;
  } vec_t;

  vec_t          vecs[5];
  logic [DW-1:0] prog[7];

  initial begin
    int sw, ss, sd, rf;
    logic [DW-1:0] w;
    logic [AW-1:0] a;
    logic [DW-1:0] bad_w;

    prog = '{16'h2340, 16'h2100, 16'h2201, 16'h3302, 16'h1211, 16'h4301, 16'h5000};
    vecs[0] = '{base: 8'h00, len: 8'd7, run: 1'b1, gap: 1'b0, mid: 1'b0, mask: 16'h0000, exp_start: 1, exp_en: 1'b1};
    vecs[1] = '{base: 8'hFE, len: 8'd3, run: 1'b0, gap: 1'b0, mid: 1'b0, mask: 16'hA5A5, exp_start: 0, exp_en: 1'b0};
    vecs[2] = '{base: 8'h20, len: 8'd0, run: 1'b1, gap: 1'b0, mid: 1'b0, mask: 16'h0000, exp_start: 1, exp_en: 1'b1};
    vecs[3] = '{base: 8'h00, len: 8'd7, run: 1'b1, gap: 1'b1, mid: 1'b1, mask: 16'h0000, exp_start: 1, exp_en: 1'b1};
    vecs[4] = '{base: 8'h80, len: 8'd2, run: 1'b0, gap: 1'b1, mid: 1'b0, mask: 16'h0F0F, exp_start: 0, exp_en: 1'b0};

    // Reset state
    #12;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_dataout", 32'(mem_dataout), 32'd0);
    check("rst_cpu_enable", 32'(cpu_enable), 32'd0);
    check("rst_cpu_start", 32'(cpu_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      sw = we_cnt; ss = start_cnt; sd = done_cnt;
      start_load(vecs[v].base, vecs[v].len, vecs[v].run);
      check("busy_after_start", 32'(busy), 32'((vecs[v].len != 0) || vecs[v].run));
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        w = prog[i] ^ vecs[v].mask;
        a = vecs[v].base + AW'(i);
        exp_q.push_back({a, w});
        send_word(w, vecs[v].gap);
        if (vecs[v].mid && i == 2) begin
          // Second load_start while busy must be ignored
          @(negedge clk);
          sdi_vld = 1'b0;
          base_addr = 8'h77;
          load_len = 8'd5;
          auto_run = 1'b0;
          load_start = 1'b1;
          @(negedge clk);
          load_start = 1'b0;
        end
      end
      idle_bus();
      wait_done(sd);
      check("we_count", 32'(we_cnt - sw), 32'(vecs[v].len));
      check("start_count", 32'(start_cnt - ss), 32'(vecs[v].exp_start));
      check("done_count", 32'(done_cnt - sd), 32'd1);
      check("cpu_enable_final", 32'(cpu_enable), 32'(vecs[v].exp_en));
      check("busy_final", 32'(busy), 32'd0);
      check("err_final", 32'(err), 32'd0);
      if (vecs[v].len != 0) check("we_latency", 32'(last_we_cyc), 32'(last_bit_cyc + 1));
      rf = (vecs[v].len == 0) ? accept_cyc : last_we_cyc;
      if (vecs[v].run) begin
        check("enable_latency", 32'(en_cyc), 32'(rf + 1));
        check("start_latency", 32'(start_cyc), 32'(rf + 2));
        check("done_latency", 32'(done_cyc), 32'(rf + 3));
      end else begin
        check("done_latency", 32'(done_cyc), 32'(rf + 1));
      end
      $display("load %0d base=0x%02h len=%0d run=%0d gap=%0d done", v, vecs[v].base, vecs[v].len, vecs[v].run, vecs[v].gap);
    end

    // Asynchronous reset after 9 bits of word 2
    start_load(8'h40, 8'd3, 1'b1);
    exp_q.push_back({8'h40, 16'h1357});
    send_word(16'h1357, 1'b0);
    exp_q.push_back({8'h41, 16'h9BDF});
    send_word(16'h9BDF, 1'b0);
    for (int i = 0; i < 9; i++) drive_bit(1'b1, 1'b0);
    @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    sdi_vld = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_mem_addr", 32'(mem_addr), 32'd0);
    check("arst_mem_dataout", 32'(mem_dataout), 32'd0);
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_cpu_enable", 32'(cpu_enable), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom), 1'b0);
    idle_bus();
    sw = we_cnt; ss = start_cnt; sd = done_cnt;
    start_load(8'h10, 8'd1, 1'b0);
    exp_q.push_back({8'h10, 16'hBEEF});
    send_word(16'hBEEF, 1'b0);
    idle_bus();
    wait_done(sd);
    check("post_reset_we_count", 32'(we_cnt - sw), 32'd1);
    check("post_reset_start_count", 32'(start_cnt - ss), 32'd0);
    $display("load after reset base=0x10 len=1 done");

`ifdef IMEM_LOADER_PARITY_EN
    // Word 1 of 3 carries a wrong parity bit
    sw = we_cnt; ss = start_cnt; sd = done_cnt;
    start_load(8'h30, 8'd3, 1'b1);
    exp_q.push_back({8'h30, 16'h0F0F});
    send_word(16'h0F0F, 1'b0);
    bad_w = 16'h1234;
    for (int i = DW - 1; i >= 0; i--) drive_bit(bad_w[i], 1'b0);
    drive_bit(~(^bad_w), 1'b0);
    exp_q.push_back({8'h32, 16'hCAFE});
    send_word(16'hCAFE, 1'b0);
    idle_bus();
    wait_done(sd);
    check("par_we_count", 32'(we_cnt - sw), 32'd2);
    check("par_err", 32'(err), 32'd1);
    check("par_start_count", 32'(start_cnt - ss), 32'd0);
    check("par_cpu_enable", 32'(cpu_enable), 32'd0);
    check("par_done_count", 32'(done_cnt - sd), 32'd1);
    $display("parity load base=0x30 len=3 done");
`else
    bad_w = '0;
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
